// File: rtl/io_timer_irq.sv
// IO-bus timer: prescaled 16-bit up-counter with compare match and a level IRQ.
// The register file sits on the 16-bit CPU IO bus, and read data is registered.
module io_timer_irq #(
  parameter logic [15:0] BASE_ADDR     = 16'h0040,
  parameter logic [15:0] PRESCALE_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        interrupt_request
);

  typedef struct packed {
    logic autoreload;
    logic irq_en;
    logic en;
  } ctrl_t;

  localparam logic [2:0] IDX_COUNT    = 3'd0;
  localparam logic [2:0] IDX_COMPARE  = 3'd1;
  localparam logic [2:0] IDX_CTRL     = 3'd2;
  localparam logic [2:0] IDX_STATUS   = 3'd3;
  localparam logic [2:0] IDX_PRESCALE = 3'd4;

  logic [15:0] count, compare, prescale, pre;
  ctrl_t       ctrl;
  logic        pending;
  logic [15:0] rdata;

  logic       sel, tick, match, en_next;
  logic [2:0] idx;
  logic       wr_count, wr_compare, wr_ctrl, wr_status, wr_prescale;
  logic       unused_ok;

  assign unused_ok = io_addr[0];

  assign sel         = io_addr[15:4] == BASE_ADDR[15:4];
  assign idx         = io_addr[3:1];
  assign wr_count    = io_wr & sel & (idx == IDX_COUNT);
  assign wr_compare  = io_wr & sel & (idx == IDX_COMPARE);
  assign wr_ctrl     = io_wr & sel & (idx == IDX_CTRL);
  assign wr_status   = io_wr & sel & (idx == IDX_STATUS);
  assign wr_prescale = io_wr & sel & (idx == IDX_PRESCALE);

  assign tick    = ctrl.en & (pre == prescale);
  assign match   = count == compare;
  assign en_next = wr_ctrl ? io_dout[0] : ctrl.en;

  assign interrupt_request = pending & ctrl.irq_en;

  always_comb begin
    rdata = 16'h0000;
    case (idx)
      IDX_COUNT:    rdata = count;
      IDX_COMPARE:  rdata = compare;
      IDX_CTRL:     rdata = {13'h0000, ctrl};
      IDX_STATUS:   rdata = {15'h0000, pending};
      IDX_PRESCALE: rdata = prescale;
      default:      rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      count    <= 16'h0000;
      compare  <= 16'h0000;
      ctrl     <= '0;
      pending  <= 1'b0;
      prescale <= PRESCALE_INIT;
      pre      <= 16'h0000;
      io_din   <= 16'h0000;
    end else begin
      // Clearing en still lets a due tick fire, but restarts the prescale period.
      if (!ctrl.en || !en_next) pre <= 16'h0000;
      else if (tick)            pre <= 16'h0000;
      else                      pre <= pre + 16'd1;

      // CPU write to COUNT beats the tick increment; match still uses old values.
      if (wr_count)      count <= io_dout;
      else if (tick)     count <= (match && ctrl.autoreload) ? 16'h0000 : count + 16'd1;

      // A new match beats a same-cycle W1C.
      if (tick && match)                 pending <= 1'b1;
      else if (wr_status && io_dout[0])  pending <= 1'b0;

      if (wr_compare)  compare  <= io_dout;
      if (wr_ctrl)     ctrl     <= ctrl_t'(io_dout[2:0]);
      if (wr_prescale) prescale <= io_dout;

      if (io_rd) io_din <= sel ? rdata : 16'h0000;
    end
  end

endmodule

// File: tb/tb_io_timer_irq.sv
// Directed bench for io_timer_irq: reset, match/IRQ, autoreload, wrap, decode, races.
module tb_io_timer_irq;

  localparam logic [15:0] BASE  = 16'h0040;
  localparam logic [15:0] PINIT = 16'h0007;
  localparam logic [15:0] A_COUNT = BASE + 16'h0, A_CMP = BASE + 16'h2, A_CTRL = BASE + 16'h4,
                          A_STAT  = BASE + 16'h6, A_PRE = BASE + 16'h8;

  logic        clk = 1'b0;
  logic        resetq;
  logic        io_rd, io_wr;
  logic [15:0] io_addr, io_dout;
  logic [15:0] io_din;
  logic        interrupt_request;

  int n_chk = 0;
  int n_fail = 0;

  io_timer_irq #(.BASE_ADDR(BASE), .PRESCALE_INIT(PINIT)) dut (
    .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr),
    .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din),
    .interrupt_request(interrupt_request)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic io_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    io_wr = 1'b1; io_addr = a; io_dout = d;
    @(posedge clk); #1;
    io_wr = 1'b0;
  endtask

  task automatic io_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    io_rd = 1'b1; io_addr = a;
    @(posedge clk); #1;
    io_rd = 1'b0;
    d = io_din;
  endtask

  logic [15:0] rd;
  logic [15:0] exp_seq [12];

  initial begin
    // Reset with a write to COUNT held active the whole time
    resetq = 1'b0; io_rd = 1'b0; io_wr = 1'b1; io_addr = A_COUNT; io_dout = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    resetq = 1'b1; io_wr = 1'b0;
    chk("rst_irq", {15'd0, interrupt_request}, 16'h0);
    chk("rst_din", io_din, 16'h0);
    for (int i = 0; i < 8; i++) begin
      io_read(BASE + 16'(2 * i), rd);
      chk($sformatf("rst_reg%0d", i), rd, (i == 4) ? PINIT : 16'h0);
    end

    // Basic match: 6th tick lands 24 cycles after the CTRL write
    io_write(A_PRE, 16'd3);
    io_write(A_CMP, 16'd5);
    io_write(A_CTRL, 16'h0003);
    repeat (23) @(posedge clk);
    #1;
    chk("match_irq_early", {15'd0, interrupt_request}, 16'h0);
    @(posedge clk); #1;
    chk("match_irq_set", {15'd0, interrupt_request}, 16'h1);
    io_read(A_COUNT, rd);
    chk("match_count", rd, 16'd6);
    io_read(A_STAT, rd);
    chk("match_status", rd, 16'h1);
    io_write(A_CTRL, 16'h0000);
    chk("ctrl_off_irq", {15'd0, interrupt_request}, 16'h0);
    io_write(A_STAT, 16'h0001);
    io_write(A_COUNT, 16'h0000);

    // Autoreload with a tick every cycle
    io_write(A_PRE, 16'd0);
    io_write(A_CTRL, 16'h0007);
    for (int i = 0; i < 12; i++) exp_seq[i] = 16'(i % 6);
    for (int i = 0; i < 12; i++) begin
      io_read(A_COUNT, rd);
      chk($sformatf("auto_cnt%0d", i), rd, exp_seq[i]);
      if (i == 4) chk("auto_irq_pre", {15'd0, interrupt_request}, 16'h0);
      if (i == 5) chk("auto_irq_1", {15'd0, interrupt_request}, 16'h1);
    end
    chk("auto_irq_2", {15'd0, interrupt_request}, 16'h1);
    io_write(A_STAT, 16'h0001);
    chk("auto_w1c_irq", {15'd0, interrupt_request}, 16'h0);
    io_write(A_CTRL, 16'h0000);
    io_write(A_STAT, 16'h0001);

    // Wrap through FFFF with no flag, then match at 1
    io_write(A_COUNT, 16'hFFFF);
    io_write(A_CMP, 16'h0001);
    io_write(A_CTRL, 16'h0003);
    io_read(A_COUNT, rd); chk("wrap_cnt0", rd, 16'hFFFF);
    io_read(A_COUNT, rd); chk("wrap_cnt1", rd, 16'h0000);
    chk("wrap_noflag", {15'd0, interrupt_request}, 16'h0);
    io_read(A_COUNT, rd); chk("wrap_cnt2", rd, 16'h0001);
    chk("wrap_match_irq", {15'd0, interrupt_request}, 16'h1);

    // W1C on the match edge: set wins
    io_write(A_CTRL, 16'h0000);
    io_write(A_STAT, 16'h0001);
    io_write(A_COUNT, 16'h0000);
    io_write(A_CTRL, 16'h0003);
    @(posedge clk); #1;
    chk("race_w1c_pre", {15'd0, interrupt_request}, 16'h0);
    io_write(A_STAT, 16'h0001);
    chk("race_w1c_irq", {15'd0, interrupt_request}, 16'h1);
    io_read(A_STAT, rd);
    chk("race_w1c_stat", rd, 16'h1);
    io_write(A_CTRL, 16'h0000);
    io_write(A_STAT, 16'h0001);

    // Read timing and address decode
    io_write(A_CMP, 16'h1234);
    io_write(16'h0082, 16'hBEEF);
    io_read(16'h0080, rd);
    chk("dec_off_0", rd, 16'h0);
    @(negedge clk);
    io_rd = 1'b1; io_addr = A_CMP;
    #1;
    chk("rd_lat_before", io_din, 16'h0);
    @(posedge clk); #1;
    io_rd = 1'b0;
    chk("rd_lat_after", io_din, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rd_hold%0d", i), io_din, 16'h1234);
    end
    io_read(16'h0080, rd);
    chk("dec_off_1", rd, 16'h0);

    // COUNT write in a tick cycle beats the increment
    io_write(A_COUNT, 16'h0000);
    io_write(A_CTRL, 16'h0001);
    io_write(A_COUNT, 16'h0100);
    io_read(A_COUNT, rd);
    chk("wr_tick_race", rd, 16'h0100);
    io_write(A_CTRL, 16'h0000);

    // Reset mid-operation drops pending IRQ and read data
    io_write(A_STAT, 16'h0001);
    io_write(A_COUNT, 16'h0000);
    io_write(A_CMP, 16'h0000);
    io_write(A_CTRL, 16'h0003);
    @(posedge clk); #1;
    chk("mid_irq", {15'd0, interrupt_request}, 16'h1);
    io_read(A_CTRL, rd);
    chk("mid_ctrl", rd, 16'h0003);
    @(negedge clk); resetq = 1'b0;
    @(posedge clk); #1; resetq = 1'b1;
    chk("mid_rst_irq", {15'd0, interrupt_request}, 16'h0);
    chk("mid_rst_din", io_din, 16'h0);
    io_read(A_STAT, rd);  chk("mid_rst_stat", rd, 16'h0);
    io_read(A_COUNT, rd); chk("mid_rst_cnt", rd, 16'h0);
    io_read(A_PRE, rd);   chk("mid_rst_pre", rd, PINIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/io_timer_irq.md
Name: io_timer_irq

Overview:
- Memory-mapped timer peripheral on the CPU's 16-bit IO bus; it is the responder for the CPU's io_rd/io_wr strobes.
- Provides a prescaled 16-bit up-counter with a compare match.
- Drives the CPU's level-sensitive interrupt_request input.
- io_din is registered and ORed with other peripherals' outputs, so it reads 0 when this block is not selected.

Parameters:
- BASE_ADDR, 16'h0040: byte base address. The block is selected when io_addr[15:4] == BASE_ADDR[15:4].
- PRESCALE_INIT, 16'h0000: reset value of the PRESCALE register.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- resetq  input  1  synchronous, active-low reset.
- io_rd  input  1  CPU IO read strobe, single-cycle.
- io_wr  input  1  CPU IO write strobe, single-cycle.
- io_addr  input  16  IO byte address, valid while io_rd or io_wr is high.
- io_dout  input  16  CPU write data, valid with io_wr.
- io_din  output  16  registered read data to the CPU.
- interrupt_request  output  1  level IRQ: pending & irq_en.

Behaviour:
- Register select: sel = io_addr[15:4] == BASE_ADDR[15:4]. Register index is io_addr[3:1]; io_addr[0] is ignored.
- Register map by index:
  - 0 COUNT: R/W.
  - 1 COMPARE: R/W.
  - 2 CTRL: R/W. bit0 en, bit1 irq_en, bit2 autoreload; other bits read 0.
  - 3 STATUS: bit0 pending, read; writing 1 to bit0 clears it (W1C).
  - 4 PRESCALE: R/W.
  - 5-7: read 0, writes ignored.
- Reset (resetq low at a rising edge) sets:
  - COUNT = 0, COMPARE = 0, CTRL = 0, pending = 0, PRESCALE = PRESCALE_INIT.
  - Prescaler counter pre = 0.
  - io_din = 0, interrupt_request = 0.
  - Reset mid-operation discards all state, including a pending IRQ and any in-flight read data.
- Write protocol:
  - On a cycle with io_wr & sel, the addressed register takes io_dout at that rising edge.
  - No wait states; no acknowledge.
  - io_wr without sel has no effect.
- Read protocol:
  - On a cycle with io_rd, io_din <= (sel ? register value sampled that cycle : 0).
  - The value is visible from the next cycle and held until the next io_rd from any source.
  - Read latency is exactly 1 cycle.
  - io_rd and io_wr are never both high; if they are, the write is performed and the read also captures the pre-write value.
- Prescaler:
  - Runs only while en = 1.
  - tick = en & (pre == PRESCALE). On tick, pre <= 0; otherwise, while en = 1, pre <= pre + 1.
  - PRESCALE = 0 gives a tick every cycle.
  - While en = 0, pre is held at 0; enabling starts a fresh prescale period.
  - A write to PRESCALE takes effect from the next cycle. If pre > new PRESCALE, pre counts up and wraps through 16'hFFFF to 0 before the next tick; this is not corrected.
- Counter on tick:
  - If COUNT == COMPARE: pending <= 1, and COUNT <= autoreload ? 0 : COUNT + 1.
  - Otherwise COUNT <= COUNT + 1, with modulo-2^16 wrap (16'hFFFF -> 0, no flag).
- Simultaneous events:
  - A CPU write to COUNT in a tick cycle wins; the tick increment is lost. The match check in that cycle still uses the old COUNT.
  - A W1C clear of pending in the same cycle as a new match: set wins, pending stays 1.
  - A write to COMPARE in a tick cycle: the match uses the old COMPARE.
  - A write to CTRL clearing en: the tick in that cycle still occurs if due; afterwards pre = 0.
- interrupt_request:
  - Combinational AND of the pending and irq_en flops; no glitch source.
  - Stays high until software clears pending or irq_en.
  - The CPU masks re-entry itself.

Test Plan:
- Reset check: hold resetq low 2 cycles with io_wr = 1 to COUNT. Release, then read all 8 indices. Expect every value 0 except PRESCALE = PRESCALE_INIT, and interrupt_request = 0.
- Basic match with IRQ: write PRESCALE = 3, COMPARE = 5, CTRL = 3'b011. Expect pending = 1 on the 6th tick, 24 cycles after the CTRL write. interrupt_request rises the same cycle; COUNT continues to 6.
- Autoreload: same setup with CTRL = 3'b111 and PRESCALE = 0. Expect the COUNT sequence 0..5, 0..5; pending set every 6 cycles. Write STATUS = 1 between matches; expect interrupt_request to drop the next cycle.
- Wrap and collisions:
  - Write COUNT = 16'hFFFF, COMPARE = 16'h0001, PRESCALE = 0, en = 1. Expect COUNT to go 0, 1, then pending; no flag at the wrap.
  - Issue a W1C on the match cycle; expect pending to remain 1.
- Read timing and decode:
  - io_rd to BASE_ADDR+2 (COMPARE = 16'h1234). Expect io_din = 16'h1234 exactly one cycle later, held for 5 idle cycles.
  - io_rd to address 16'h0080. Expect io_din = 0 the next cycle.
- Write/tick race: with PRESCALE = 0 and en = 1, write COUNT = 16'h0100 in a tick cycle. Expect a readback of 16'h0100 before further ticks, not 16'h0101.
